video_pattern_gen: RTL and testbench
====================================

VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel bit width (matches the downstream scaler stream).
REQ-002 SHALL have parameter CNT_WIDTH, default 12, width of all timing and coordinate fields.
REQ-003 SHALL have parameter CHK_BIT, default 4, coordinate bit selecting checker square size (16 px at default).
REQ-004 SHALL have one clock and asynchronous active-low reset; clocking and reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-005 SHALL have ports:
- enable  input  1  run request
- h_sync, h_bp, h_active, h_fp  input  CNT_WIDTH each  horizontal phase lengths in clocks
- v_sync, v_bp, v_active, v_fp  input  CNT_WIDTH each  vertical phase lengths in lines
- pattern_sel  input  2  0 H-ramp, 1 V-ramp, 2 checker, 3 solid
- color  input  DATA_WIDTH  solid value
- do_o  output  DATA_WIDTH  pixel
- de_o, hs_o, vs_o  output  1 each  active-video, line sync, frame sync
- frame_done_o  output  1  one-clock end-of-frame pulse
- busy_o  output  1  state is RUN

Function
REQ-006 SHALL implement FSM IDLE/RUN; one output sample per clock in RUN, no stall input.
REQ-007 IDLE->RUN SHALL occur at an edge where enable=1, h_active!=0, v_active!=0; at that same edge all timing inputs, pattern_sel and color SHALL be latched for the whole frame.
REQ-008 With enable=1 but h_active=0 or v_active=0, SHALL remain IDLE, outputs 0.
REQ-009 Line SHALL be h_sync, h_bp, h_active, h_fp clocks in order; h_sync=0 SHALL be treated as 1; zero-length porches SHALL be skipped.
REQ-010 Frame SHALL be v_sync, v_bp, v_active, v_fp lines in order; v_sync=0 treated as 1; zero-length porches skipped.
REQ-011 hs_o=1 during h_sync clocks of every line, including vertical blanking lines.
REQ-012 vs_o=1 for every clock of v_sync lines.
REQ-013 de_o=1 only in h_active clocks of v_active lines; de_o SHALL never be 1 while hs_o or vs_o is 1.
REQ-014 Frame clock k (k=0 first h_sync clock of first v_sync line) SHALL appear on outputs after edge N+1+k, N being the IDLE->RUN edge; all outputs registered.
REQ-015 x (0..h_active-1) and y (0..v_active-1) SHALL count active pixels/lines; x resets each line, y each frame.
REQ-016 When de_o=1, do_o SHALL be: sel0 x[DATA_WIDTH-1:0] (wraps); sel1 y[DATA_WIDTH-1:0]; sel2 all-ones if x[CHK_BIT]^y[CHK_BIT] else 0; sel3 color.
REQ-017 When de_o=0, do_o SHALL be 0.
REQ-018 frame_done_o SHALL pulse on the output cycle of the last clock of the last line of the frame.
REQ-019 At frame end with enable=1, next frame SHALL start on the next clock with no gap and with re-latched config (REQ-007 rules; invalid config -> IDLE).
REQ-020 Deassertion of enable mid-frame SHALL NOT truncate the frame; FSM returns to IDLE after frame end.
REQ-021 Config input changes mid-frame SHALL have no effect until the next frame start.
REQ-022 Phase lengths at max (2^CNT_WIDTH-1) SHALL be supported without counter wrap.

Reset
REQ-023 rst_n=0 SHALL asynchronously force IDLE, all counters 0, do_o, de_o, hs_o, vs_o, frame_done_o, busy_o to 0, including mid-frame.
REQ-024 After rst_n release, the first frame SHALL start only per REQ-007.

Verification
REQ-025 Basic timing: h=2/1/4/1, v=1/1/3/1, sel0, enable held -> 8-clk lines, 48-clk frame; hs_o 2 clks per line; vs_o clks 0-7; de_o 4 clks on lines 2-4; do_o 0,1,2,3 per line; frame_done_o at clk 47; frame 2 starts clk 48.
REQ-026 Patterns: h_active=32, v_active=32, sel2 -> do_o 0 for x<16,y<16, all-ones for x>=16,y<16; sel1 -> do_o equals line index y; sel3 color=0xA5 -> all active 0xA5.
REQ-027 Zero/degenerate: h_sync=0, h_bp=0, h_fp=0 -> hs_o 1 clk then immediate de_o; h_active=0 with enable=1 -> busy_o stays 0, outputs 0.
REQ-028 Enable drop: deassert enable at clk 20 of REQ-025 frame -> frame completes to clk 47, busy_o 0 from clk 48, no further outputs.
REQ-029 Reset mid-frame: assert rst_n=0 at clk 20 with de_o=1 -> all outputs 0 without a clock edge; after release with enable=1, new frame begins at clk 0 timing.
REQ-030 Config change mid-frame: change h_active 4->6 at clk 10 -> current frame unchanged, next frame lines 10 clks.

Source files
------------

// File: rtl/video_pattern_gen.sv
// Video timing and test-pattern source: a configurable raster of sync, porch and
// active phases with registered pixel/sync outputs and a per-frame config snapshot.
module video_pattern_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 12,
  parameter int CHK_BIT    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [CNT_WIDTH-1:0]  h_sync,
  input  logic [CNT_WIDTH-1:0]  h_bp,
  input  logic [CNT_WIDTH-1:0]  h_active,
  input  logic [CNT_WIDTH-1:0]  h_fp,
  input  logic [CNT_WIDTH-1:0]  v_sync,
  input  logic [CNT_WIDTH-1:0]  v_bp,
  input  logic [CNT_WIDTH-1:0]  v_active,
  input  logic [CNT_WIDTH-1:0]  v_fp,
  input  logic [1:0]            pattern_sel,
  input  logic [DATA_WIDTH-1:0] color,
  output logic [DATA_WIDTH-1:0] do_o,
  output logic                  de_o,
  output logic                  hs_o,
  output logic                  vs_o,
  output logic                  frame_done_o,
  output logic                  busy_o
);
  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_RUN  = 1'b1;

  localparam logic [1:0] PH_SYNC = 2'd0;
  localparam logic [1:0] PH_BP   = 2'd1;
  localparam logic [1:0] PH_ACT  = 2'd2;
  localparam logic [1:0] PH_FP   = 2'd3;

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  logic [0:0]            state;
  logic [CNT_WIDTH-1:0]  hs_q, hb_q, ha_q, hf_q, vs_q, vb_q, va_q, vf_q;
  logic [1:0]            sel_q;
  logic [DATA_WIDTH-1:0] color_q;
  logic [1:0]            h_ph, v_ph;
  logic [CNT_WIDTH-1:0]  h_cnt, v_cnt;

  logic                  start_ok, load;
  logic [CNT_WIDTH-1:0]  h_len, v_len;
  logic                  h_last, v_last, line_end, frame_end;
  logic [1:0]            h_ph_nxt, v_ph_nxt;
  logic                  hs_c, vs_c, de_c;
  logic [DATA_WIDTH-1:0] pix_c;
  logic [CNT_WIDTH+DATA_WIDTH-1:0] x_ext, y_ext;

  assign start_ok = enable && (h_active != '0) && (v_active != '0);
  // A frame boundary in RUN re-samples the config exactly like the first start.
  assign load     = ((state == STATE_IDLE) || frame_end) && start_ok;

  always_comb begin
    h_len = hs_q;
    case (h_ph)
      PH_BP:   h_len = hb_q;
      PH_ACT:  h_len = ha_q;
      PH_FP:   h_len = hf_q;
      default: h_len = hs_q;
    endcase
    v_len = vs_q;
    case (v_ph)
      PH_BP:   v_len = vb_q;
      PH_ACT:  v_len = va_q;
      PH_FP:   v_len = vf_q;
      default: v_len = vs_q;
    endcase
  end

  // Comparing against len-1 keeps counters within CNT_WIDTH even at max lengths.
  assign h_last    = (h_cnt == h_len - ONE);
  assign v_last    = (v_cnt == v_len - ONE);
  assign line_end  = h_last && ((h_ph == PH_FP) || ((h_ph == PH_ACT) && (hf_q == '0)));
  assign frame_end = (state == STATE_RUN) && line_end && v_last &&
                     ((v_ph == PH_FP) || ((v_ph == PH_ACT) && (vf_q == '0)));

  always_comb begin
    h_ph_nxt = PH_SYNC;
    case (h_ph)
      PH_SYNC: h_ph_nxt = (hb_q != '0) ? PH_BP : PH_ACT;
      PH_BP:   h_ph_nxt = PH_ACT;
      PH_ACT:  h_ph_nxt = (hf_q != '0) ? PH_FP : PH_SYNC;
      default: h_ph_nxt = PH_SYNC;
    endcase
    v_ph_nxt = PH_SYNC;
    case (v_ph)
      PH_SYNC: v_ph_nxt = (vb_q != '0) ? PH_BP : PH_ACT;
      PH_BP:   v_ph_nxt = PH_ACT;
      PH_ACT:  v_ph_nxt = (vf_q != '0) ? PH_FP : PH_SYNC;
      default: v_ph_nxt = PH_SYNC;
    endcase
  end

  assign hs_c  = (h_ph == PH_SYNC);
  assign vs_c  = (v_ph == PH_SYNC);
  assign de_c  = (h_ph == PH_ACT) && (v_ph == PH_ACT);
  assign x_ext = {{DATA_WIDTH{1'b0}}, h_cnt};
  assign y_ext = {{DATA_WIDTH{1'b0}}, v_cnt};

  always_comb begin
    pix_c = '0;
    if (de_c) begin
      case (sel_q)
        2'd0:    pix_c = x_ext[DATA_WIDTH-1:0];
        2'd1:    pix_c = y_ext[DATA_WIDTH-1:0];
        2'd2:    pix_c = (h_cnt[CHK_BIT] ^ v_cnt[CHK_BIT]) ? '1 : '0;
        default: pix_c = color_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q <= '0; hb_q <= '0; ha_q <= '0; hf_q <= '0;
      vs_q <= '0; vb_q <= '0; va_q <= '0; vf_q <= '0;
      sel_q <= '0; color_q <= '0;
    end else if (load) begin
      hs_q <= (h_sync == '0) ? ONE : h_sync;
      hb_q <= h_bp; ha_q <= h_active; hf_q <= h_fp;
      vs_q <= (v_sync == '0) ? ONE : v_sync;
      vb_q <= v_bp; va_q <= v_active; vf_q <= v_fp;
      sel_q <= pattern_sel; color_q <= color;
    end
  end

  // Outputs show the raster position the counters held at the previous edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= STATE_IDLE;
      h_ph <= PH_SYNC; h_cnt <= '0; v_ph <= PH_SYNC; v_cnt <= '0;
      do_o <= '0; de_o <= 1'b0; hs_o <= 1'b0; vs_o <= 1'b0;
      frame_done_o <= 1'b0; busy_o <= 1'b0;
    end else if (state == STATE_RUN) begin
      do_o <= pix_c; de_o <= de_c; hs_o <= hs_c; vs_o <= vs_c;
      frame_done_o <= frame_end; busy_o <= 1'b1;
      if (h_last) begin
        h_cnt <= '0;
        h_ph  <= h_ph_nxt;
      end else begin
        h_cnt <= h_cnt + ONE;
      end
      if (line_end) begin
        if (v_last) begin
          v_cnt <= '0;
          v_ph  <= v_ph_nxt;
        end else begin
          v_cnt <= v_cnt + ONE;
        end
      end
      if (frame_end && !start_ok) state <= STATE_IDLE;
    end else begin
      do_o <= '0; de_o <= 1'b0; hs_o <= 1'b0; vs_o <= 1'b0;
      frame_done_o <= 1'b0; busy_o <= 1'b0;
      h_ph <= PH_SYNC; h_cnt <= '0; v_ph <= PH_SYNC; v_cnt <= '0;
      if (start_ok) state <= STATE_RUN;
    end
  end
endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen: per-clock comparison of the registered
// outputs against a raster position model derived from the phase lengths.
module tb_video_pattern_gen;
  localparam int DW = 8;
  localparam int CW = 12;

  logic          clk, rst_n, enable;
  logic [CW-1:0] h_sync, h_bp, h_active, h_fp, v_sync, v_bp, v_active, v_fp;
  logic [1:0]    pattern_sel;
  logic [DW-1:0] color;
  logic [DW-1:0] do_o;
  logic          de_o, hs_o, vs_o, frame_done_o, busy_o;

  typedef struct {
    logic [CW-1:0] hs, hb, ha, hf, vs, vb, va, vf;
    logic [1:0]    sel;
    logic [DW-1:0] color;
  } cfg_t;

  int checks = 0;
  int failures = 0;

  video_pattern_gen #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .CHK_BIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .h_sync(h_sync), .h_bp(h_bp), .h_active(h_active), .h_fp(h_fp),
    .v_sync(v_sync), .v_bp(v_bp), .v_active(v_active), .v_fp(v_fp),
    .pattern_sel(pattern_sel), .color(color),
    .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o),
    .frame_done_o(frame_done_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed output vector {busy, frame_done, vs, hs, de, do}.
  function automatic logic [DW+4:0] obs();
    return {busy_o, frame_done_o, vs_o, hs_o, de_o, do_o};
  endfunction

  // Expected outputs for frame clock k, from positions within line and frame.
  function automatic logic [DW+4:0] exp_out(cfg_t c, int k);
    int hsl, vsl, lh, lv, line, p, x, y, pix;
    logic de;
    hsl = (c.hs == 0) ? 1 : int'(c.hs);
    vsl = (c.vs == 0) ? 1 : int'(c.vs);
    lh = hsl + int'(c.hb) + int'(c.ha) + int'(c.hf);
    lv = vsl + int'(c.vb) + int'(c.va) + int'(c.vf);
    line = k / lh;
    p = k % lh;
    x = p - hsl - int'(c.hb);
    y = line - vsl - int'(c.vb);
    de = (x >= 0) && (x < int'(c.ha)) && (y >= 0) && (y < int'(c.va));
    pix = 0;
    if (de) begin
      case (c.sel)
        2'd0: pix = x & 255;
        2'd1: pix = y & 255;
        2'd2: pix = (((x >> 4) ^ (y >> 4)) & 1) ? 255 : 0;
        default: pix = int'(c.color);
      endcase
    end
    return {1'b1, (k == lh * lv - 1), (line < vsl), (p < hsl), de, DW'(pix)};
  endfunction

  function automatic int frame_len(cfg_t c);
    int hsl, vsl;
    hsl = (c.hs == 0) ? 1 : int'(c.hs);
    vsl = (c.vs == 0) ? 1 : int'(c.vs);
    return (hsl + int'(c.hb) + int'(c.ha) + int'(c.hf)) *
           (vsl + int'(c.vb) + int'(c.va) + int'(c.vf));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_cfg(cfg_t c);
    h_sync = c.hs; h_bp = c.hb; h_active = c.ha; h_fp = c.hf;
    v_sync = c.vs; v_bp = c.vb; v_active = c.va; v_fp = c.vf;
    pattern_sel = c.sel; color = c.color;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Enable at the next edge (the start edge) and advance to frame clock 0.
  task automatic start_run();
    enable = 1'b1;
    step();
    step();
  endtask

  function automatic cfg_t basic_cfg();
    cfg_t c;
    c.hs = 2; c.hb = 1; c.ha = 4; c.hf = 1;
    c.vs = 1; c.vb = 1; c.va = 3; c.vf = 1;
    c.sel = 2'd0; c.color = 8'h00;
    return c;
  endfunction

  task automatic test_reset();
    cfg_t c;
    logic [DW+4:0] o;
    c = basic_cfg();
    apply_cfg(c);
    enable = 1'b0;
    rst_n = 1'b0;
    #1;
    o = obs();
    checks++;
    if (o !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=%h", o, 13'h0);
    end
    rst_n = 1'b1;
    step();
    step();
    o = obs();
    checks++;
    if (o !== '0) begin
      failures++;
      $display("FAIL idle_after_reset got=%h exp=%h", o, 13'h0);
    end
  endtask

  task automatic test_basic_timing();
    cfg_t c;
    logic [DW+4:0] o, e;
    c = basic_cfg();
    do_reset();
    apply_cfg(c);
    start_run();
    // Two frames back to back: 96 clocks, second frame starts at clock 48.
    for (int k = 0; k < 96; k++) begin
      o = obs();
      e = exp_out(c, k % 48);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL basic_timing k=%0d got=%h exp=%h", k, o, e);
      end
      step();
    end
  endtask

  task automatic test_patterns();
    cfg_t c;
    logic [DW+4:0] o, e;
    int n;
    c.hs = 1; c.hb = 0; c.ha = 32; c.hf = 0;
    c.vs = 1; c.vb = 0; c.va = 32; c.vf = 0;
    c.color = 8'hA5;
    for (int s = 1; s < 4; s++) begin
      c.sel = 2'(s);
      do_reset();
      apply_cfg(c);
      start_run();
      n = frame_len(c);
      for (int k = 0; k < n; k++) begin
        o = obs();
        e = exp_out(c, k);
        checks++;
        if (o !== e) begin
          failures++;
          $display("FAIL pattern_sel%0d k=%0d got=%h exp=%h", s, k, o, e);
        end
        step();
      end
    end
  endtask

  task automatic test_zero_porches();
    cfg_t c;
    logic [DW+4:0] o, e;
    c.hs = 0; c.hb = 0; c.ha = 4; c.hf = 0;
    c.vs = 0; c.vb = 0; c.va = 2; c.vf = 0;
    c.sel = 2'd0; c.color = 8'h00;
    do_reset();
    apply_cfg(c);
    start_run();
    for (int k = 0; k < 15; k++) begin
      o = obs();
      e = exp_out(c, k);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL zero_porch k=%0d got=%h exp=%h", k, o, e);
      end
      step();
    end
    c.ha = 0;
    do_reset();
    apply_cfg(c);
    enable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      o = obs();
      checks++;
      if (o !== '0) begin
        failures++;
        $display("FAIL zero_active_idle k=%0d got=%h exp=%h", k, o, 13'h0);
      end
    end
  endtask

  task automatic test_enable_drop();
    cfg_t c;
    logic [DW+4:0] o, e;
    c = basic_cfg();
    do_reset();
    apply_cfg(c);
    start_run();
    for (int k = 0; k < 60; k++) begin
      o = obs();
      e = (k < 48) ? exp_out(c, k) : '0;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL enable_drop k=%0d got=%h exp=%h", k, o, e);
      end
      if (k == 20) enable = 1'b0;
      step();
    end
  endtask

  task automatic test_reset_mid_frame();
    cfg_t c;
    logic [DW+4:0] o, e;
    c = basic_cfg();
    do_reset();
    apply_cfg(c);
    start_run();
    for (int k = 0; k < 20; k++) step();
    checks++;
    if (de_o !== 1'b1) begin
      failures++;
      $display("FAIL mid_frame_de got=%b exp=%b", de_o, 1'b1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    o = obs();
    checks++;
    if (o !== '0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", o, 13'h0);
    end
    #2;
    rst_n = 1'b1;
    step();
    step();
    for (int k = 0; k < 16; k++) begin
      o = obs();
      e = exp_out(c, k);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL restart_after_reset k=%0d got=%h exp=%h", k, o, e);
      end
      step();
    end
  endtask

  task automatic test_config_change();
    cfg_t c, c2;
    logic [DW+4:0] o, e;
    c = basic_cfg();
    c2 = c;
    c2.ha = 6;
    do_reset();
    apply_cfg(c);
    start_run();
    for (int k = 0; k < 48 + 60; k++) begin
      o = obs();
      e = (k < 48) ? exp_out(c, k) : exp_out(c2, k - 48);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL config_change k=%0d got=%h exp=%h", k, o, e);
      end
      if (k == 10) h_active = 12'd6;
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    test_reset();
    test_basic_timing();
    test_patterns();
    test_zero_porches();
    test_enable_drop();
    test_reset_mid_frame();
    test_config_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
